// File: rtl/branch_resolve.sv
// -----------------------------------------------------------------------------
// branch_resolve
//   EX-stage branch resolution for the pd5 pipeline. Decides taken/not-taken for
//   B-type, JAL and JALR using the comparator flags, computes the real target,
//   checks it against the fetch-stage prediction and, on a mispredict, issues a
//   registered one-cycle redirect followed by a multi-cycle front-end flush.
//   Keeps wrapping counters of resolved control transfers and mispredicts.
//
// Ports
//   clk_i, rst_ni           clock, asynchronous active-low reset
//   valid_i, stall_i        EX instruction present / not consumed this cycle
//   opcode_i, funct3_i      EX instruction decode fields
//   pc_i, imm_i, rs1_i      EX PC, sign-extended immediate, JALR base
//   breq_i, brlt_i          comparator flags (signedness already applied)
//   pred_taken_i/target_i   fetch-stage prediction
//   taken_o, illegal_o      combinational resolution of the accepted instruction
//   redirect_valid_o/pc_o   registered redirect strobe and correct next PC
//   flush_o                 kill IF/ID contents
//   branch_count_o          resolved control transfers
//   mispredict_count_o      mispredicts
// -----------------------------------------------------------------------------
module branch_resolve #(
    parameter int unsigned AWIDTH       = 32,
    parameter int unsigned DWIDTH       = 32,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    input  logic              stall_i,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        funct3_i,
    input  logic [AWIDTH-1:0] pc_i,
    input  logic [DWIDTH-1:0] imm_i,
    input  logic [DWIDTH-1:0] rs1_i,
    input  logic              breq_i,
    input  logic              brlt_i,
    input  logic              pred_taken_i,
    input  logic [AWIDTH-1:0] pred_target_i,
    output logic              taken_o,
    output logic              redirect_valid_o,
    output logic [AWIDTH-1:0] redirect_pc_o,
    output logic              flush_o,
    output logic              illegal_o,
    output logic [CNT_W-1:0]  branch_count_o,
    output logic [CNT_W-1:0]  mispredict_count_o
);

    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;

    // Residual flush cycles after the REDIRECT cycle (FLUSH_CYCLES is 1..7).
    localparam logic [2:0] FLUSH_LAST = 3'(FLUSH_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REDIRECT,
        ST_FLUSH
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               redirect_valid_q, redirect_valid_d;
    logic               flush_q, flush_d;
    logic [AWIDTH-1:0]  redirect_pc_q, redirect_pc_d;
    logic [CNT_W-1:0]   branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0]   mispred_cnt_q, mispred_cnt_d;

    // Operands brought to PC width; sign extension/truncation keeps mod-2^AWIDTH sums.
    logic [AWIDTH-1:0]  imm_a;
    logic [AWIDTH-1:0]  rs1_a;
    logic [AWIDTH-1:0]  pc_rel_target;
    logic [AWIDTH-1:0]  jalr_sum;
    logic [AWIDTH-1:0]  target;
    logic [AWIDTH-1:0]  next_pc;

    logic is_branch;
    logic is_jal;
    logic is_jalr;
    logic is_ctrl;
    logic accept;
    logic branch_taken;
    logic branch_illegal;
    logic taken_raw;
    logic mispredict;

    assign imm_a = AWIDTH'($signed(imm_i));
    assign rs1_a = AWIDTH'($signed(rs1_i));

    always_comb begin
        is_branch = (opcode_i == OP_BRANCH);
        is_jal    = (opcode_i == OP_JAL);
        is_jalr   = (opcode_i == OP_JALR);
        is_ctrl   = is_branch | is_jal | is_jalr;

        // Wrong-path instructions behind a redirect are never accepted.
        accept    = valid_i & ~stall_i & (state_q == ST_IDLE);

        branch_taken   = 1'b0;
        branch_illegal = 1'b0;
        unique case (funct3_i)
            3'b000:          branch_taken = breq_i;
            3'b001:          branch_taken = ~breq_i;
            3'b100, 3'b110:  branch_taken = brlt_i;
            3'b101, 3'b111:  branch_taken = ~brlt_i;
            default:         branch_illegal = 1'b1;
        endcase

        taken_raw = is_jal | is_jalr | (is_branch & branch_taken);

        pc_rel_target = pc_i + imm_a;
        jalr_sum      = rs1_a + imm_a;
        target        = is_jalr ? {jalr_sum[AWIDTH-1:1], 1'b0} : pc_rel_target;
        next_pc       = taken_raw ? target : (pc_i + AWIDTH'(4));

        mispredict = accept & is_ctrl &
                     ((taken_raw != pred_taken_i) |
                      (taken_raw & (target != pred_target_i)));
    end

    assign taken_o   = accept & is_ctrl & taken_raw;
    assign illegal_o = accept & is_branch & branch_illegal;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        redirect_pc_d = redirect_pc_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;

        if (accept & is_ctrl) begin
            branch_cnt_d = branch_cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            ST_IDLE: begin
                if (mispredict) begin
                    state_d       = ST_REDIRECT;
                    redirect_pc_d = next_pc;
                    mispred_cnt_d = mispred_cnt_q + CNT_W'(1);
                end
            end
            ST_REDIRECT: begin
                cnt_d   = FLUSH_LAST;
                state_d = (FLUSH_LAST != 3'd0) ? ST_FLUSH : ST_IDLE;
            end
            ST_FLUSH: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q <= 3'd1) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Strobes are decoded from the next state so they leave a flop directly.
        redirect_valid_d = (state_d == ST_REDIRECT);
        flush_d          = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q          <= ST_IDLE;
            cnt_q            <= '0;
            redirect_valid_q <= 1'b0;
            flush_q          <= 1'b0;
            redirect_pc_q    <= '0;
            branch_cnt_q     <= '0;
            mispred_cnt_q    <= '0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            redirect_valid_q <= redirect_valid_d;
            flush_q          <= flush_d;
            redirect_pc_q    <= redirect_pc_d;
            branch_cnt_q     <= branch_cnt_d;
            mispred_cnt_q    <= mispred_cnt_d;
        end
    end

    assign redirect_valid_o   = redirect_valid_q;
    assign redirect_pc_o      = redirect_pc_q;
    assign flush_o            = flush_q;
    assign branch_count_o     = branch_cnt_q;
    assign mispredict_count_o = mispred_cnt_q;

endmodule

// File: tb/tb_branch_resolve.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve
//   Scoreboard bench for branch_resolve. The driver applies one instruction per
//   cycle, evaluates a transaction-level reference model (a blocked-cycle count
//   instead of a state machine) and pushes the expected per-cycle outputs and
//   any expected redirect into queues. A separate monitor pops and compares.
// -----------------------------------------------------------------------------
module tb_branch_resolve;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned FC = 2;
    localparam int unsigned CW = 32;

    localparam logic [6:0] OP_B    = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_ALU  = 7'b0110011;

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic          valid_i, stall_i;
    logic [6:0]    opcode_i;
    logic [2:0]    funct3_i;
    logic [AW-1:0] pc_i;
    logic [DW-1:0] imm_i, rs1_i;
    logic          breq_i, brlt_i, pred_taken_i;
    logic [AW-1:0] pred_target_i;
    logic          taken_o, redirect_valid_o, flush_o, illegal_o;
    logic [AW-1:0] redirect_pc_o;
    logic [CW-1:0] branch_count_o, mispredict_count_o;

    branch_resolve #(
        .AWIDTH(AW), .DWIDTH(DW), .FLUSH_CYCLES(FC), .CNT_W(CW)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .valid_i(valid_i), .stall_i(stall_i),
        .opcode_i(opcode_i), .funct3_i(funct3_i), .pc_i(pc_i), .imm_i(imm_i),
        .rs1_i(rs1_i), .breq_i(breq_i), .brlt_i(brlt_i),
        .pred_taken_i(pred_taken_i), .pred_target_i(pred_target_i),
        .taken_o(taken_o), .redirect_valid_o(redirect_valid_o),
        .redirect_pc_o(redirect_pc_o), .flush_o(flush_o), .illegal_o(illegal_o),
        .branch_count_o(branch_count_o), .mispredict_count_o(mispredict_count_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit          taken;
        bit          illegal;
        bit          flush;
        bit          rv;
        logic [CW-1:0] bc;
        logic [CW-1:0] mc;
    } exp_t;

    exp_t          exp_q[$];
    logic [AW-1:0] rd_pc_q[$];
    int            rd_due_q[$];

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    bit done        = 0;

    // Reference model state: cycles left in which the front end is being redirected/flushed.
    int            blk  = 0;
    logic [CW-1:0] m_bc = '0;
    logic [CW-1:0] m_mc = '0;

    function automatic logic [AW-1:0] ref_target(input logic [6:0] op, input logic [AW-1:0] pc,
                                                 input logic [DW-1:0] imm, input logic [DW-1:0] rs1);
        logic [AW-1:0] s;
        if (op == OP_JALR) begin
            s = rs1 + imm;
            return s - (s % 2);
        end
        s = pc + imm;
        return s;
    endfunction

    function automatic bit ref_taken(input logic [6:0] op, input logic [2:0] f3, input bit eq, input bit lt);
        if (op == OP_JAL || op == OP_JALR) return 1'b1;
        if (op != OP_B) return 1'b0;
        case (f3)
            3'd0:       return eq;
            3'd1:       return !eq;
            3'd4, 3'd6: return lt;
            3'd5, 3'd7: return !lt;
            default:    return 1'b0;
        endcase
    endfunction

    function automatic exp_t zero_exp();
        exp_t e;
        e.taken = 0; e.illegal = 0; e.flush = 0; e.rv = 0; e.bc = '0; e.mc = '0;
        return e;
    endfunction

    task automatic apply(input bit v, input bit st, input logic [6:0] op, input logic [2:0] f3,
                         input logic [AW-1:0] pc, input logic [DW-1:0] imm, input logic [DW-1:0] rs1,
                         input bit eq, input bit lt, input bit pt, input logic [AW-1:0] ptg);
        exp_t e;
        bit ctrl, acc, tk, mis;
        logic [AW-1:0] tgt, npc;
        @(posedge clk_i);
        #1;
        valid_i = v; stall_i = st; opcode_i = op; funct3_i = f3; pc_i = pc; imm_i = imm;
        rs1_i = rs1; breq_i = eq; brlt_i = lt; pred_taken_i = pt; pred_target_i = ptg;
        cyc++;
        ctrl = (op == OP_B) || (op == OP_JAL) || (op == OP_JALR);
        acc  = v && !st && (blk == 0);
        tk   = ref_taken(op, f3, eq, lt);
        tgt  = ref_target(op, pc, imm, rs1);
        npc  = tk ? tgt : pc + 4;
        mis  = acc && ctrl && ((tk != pt) || (tk && tgt != ptg));
        e.taken   = acc && ctrl && tk;
        e.illegal = acc && (op == OP_B) && (f3 == 3'd2 || f3 == 3'd3);
        e.flush   = (blk > 0);
        e.rv      = (blk == FC);
        e.bc      = m_bc;
        e.mc      = m_mc;
        exp_q.push_back(e);
        if (blk > 0) blk--;
        if (acc && ctrl) m_bc++;
        if (mis) begin
            m_mc++;
            blk = FC;
            rd_pc_q.push_back(npc);
            rd_due_q.push_back(cyc + 1);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) apply(0, 0, OP_ALU, 3'd0, '0, '0, '0, 0, 0, 0, '0);
    endtask

    task automatic set_reset(input bit level);
        @(posedge clk_i);
        #1;
        rst_ni = level;
        valid_i = 0; stall_i = 0;
        cyc++;
        blk = 0; m_bc = '0; m_mc = '0;
        rd_pc_q.delete();
        rd_due_q.delete();
        exp_q.push_back(zero_exp());
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        if (act !== req) begin
            miscompares++;
            $display("FAIL %s cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, req);
        end
    endtask

    // Monitor: one expected record per driven cycle, plus redirect pops on the strobe.
    initial begin
        exp_t e;
        logic [AW-1:0] rpc;
        int due;
        while (!done) begin
            @(negedge clk_i);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                vectors++;
                check("taken_o", 64'(taken_o), 64'(e.taken));
                check("illegal_o", 64'(illegal_o), 64'(e.illegal));
                check("flush_o", 64'(flush_o), 64'(e.flush));
                check("redirect_valid_o", 64'(redirect_valid_o), 64'(e.rv));
                check("branch_count_o", 64'(branch_count_o), 64'(e.bc));
                check("mispredict_count_o", 64'(mispredict_count_o), 64'(e.mc));
            end
            if (rst_ni === 1'b1 && redirect_valid_o === 1'b1) begin
                if (rd_pc_q.size() == 0) begin
                    miscompares++;
                    $display("FAIL unexpected_redirect cycle %0d: got pc 0x%0h expected none", cyc, redirect_pc_o);
                end else begin
                    rpc = rd_pc_q.pop_front();
                    due = rd_due_q.pop_front();
                    check("redirect_pc_o", 64'(redirect_pc_o), 64'(rpc));
                    check("redirect_latency", 64'(cyc), 64'(due));
                end
            end
        end
    end

    initial begin
        logic [6:0]    op;
        logic [2:0]    f3;
        logic [AW-1:0] pc, ptg;
        logic [DW-1:0] imm, rs1;
        bit            eq, lt, pt;

        rst_ni = 0; valid_i = 0; stall_i = 0; opcode_i = '0; funct3_i = '0; pc_i = '0;
        imm_i = '0; rs1_i = '0; breq_i = 0; brlt_i = 0; pred_taken_i = 0; pred_target_i = '0;
        set_reset(0);
        set_reset(1);

        // BEQ taken, predicted not taken -> redirect to 0x120, two flush cycles.
        apply(1, 0, OP_B, 3'd0, 32'h100, 32'h20, '0, 1, 0, 0, '0);
        idle(4);
        // BNE not taken, predicted taken -> redirect to pc+4.
        apply(1, 0, OP_B, 3'd1, 32'h200, 32'h40, '0, 1, 0, 1, 32'h240);
        idle(4);
        // JALR with odd sum, correct prediction -> no redirect.
        apply(1, 0, OP_JALR, 3'd0, 32'h500, 32'h4, 32'h1001, 0, 0, 1, 32'h1004);
        idle(2);
        // Mispredict, then mispredicting BLTs in the redirect and flush cycles are ignored.
        apply(1, 0, OP_B, 3'd0, 32'h100, 32'h20, '0, 1, 0, 0, '0);
        apply(1, 0, OP_B, 3'd4, 32'h300, 32'h80, '0, 0, 1, 0, '0);
        apply(1, 0, OP_B, 3'd4, 32'h300, 32'h80, '0, 0, 1, 0, '0);
        idle(3);
        // Stalled mispredicting BGE does nothing; released it redirects; reset during flush.
        apply(1, 1, OP_B, 3'd5, 32'h400, 32'h10, '0, 0, 0, 0, '0);
        apply(1, 0, OP_B, 3'd5, 32'h400, 32'h10, '0, 0, 0, 0, '0);
        idle(1);
        set_reset(0);
        set_reset(0);
        set_reset(1);
        idle(2);
        // Illegal B-type funct3 values.
        apply(1, 0, OP_B, 3'd2, 32'h600, 32'h8, '0, 1, 1, 0, '0);
        apply(1, 0, OP_B, 3'd3, 32'h600, 32'h8, '0, 0, 0, 0, '0);
        // JAL target wraps; correct then wrong predicted target.
        apply(1, 0, OP_JAL, 3'd0, 32'hFFFFFFF0, 32'h20, '0, 0, 0, 1, 32'h10);
        apply(1, 0, OP_JAL, 3'd0, 32'hFFFFFFF0, 32'h20, '0, 0, 0, 1, 32'h14);
        idle(3);
        // Non-control opcode never resolves.
        apply(1, 0, OP_ALU, 3'd0, 32'h700, 32'h8, '0, 1, 1, 1, 32'h708);
        idle(1);

        for (int n = 0; n < 3000; n++) begin
            case ($urandom_range(0, 4))
                0, 1:    op = OP_B;
                2:       op = OP_JAL;
                3:       op = OP_JALR;
                default: begin
                    op = 7'($urandom);
                    if (op == OP_B || op == OP_JAL || op == OP_JALR) op = OP_ALU;
                end
            endcase
            f3  = 3'($urandom);
            pc  = {$urandom_range(0, 255), 2'b00};
            imm = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 64)) - 32'd32;
            rs1 = $urandom_range(0, 1023);
            eq  = 1'($urandom);
            lt  = 1'($urandom);
            pt  = 1'($urandom);
            ptg = ($urandom_range(0, 1) == 0) ? ref_target(op, pc, imm, rs1) : $urandom;
            apply($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, op, f3, pc, imm, rs1,
                  eq, lt, pt, ptg);
        end
        idle(4);

        @(negedge clk_i);
        #1;
        done = 1;
        if (exp_q.size() != 0 || rd_pc_q.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_expectations: got %0d/%0d pending expected 0/0", exp_q.size(), rd_pc_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
